// File: rtl/mem_store_unit_pkg.sv
// Shared encodings for the memory-stage store unit.
package mem_store_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;
    localparam int unsigned ST_W = 3;

    // Store type encodings from the memory-stage decode; 4-7 behave as none.
    typedef enum logic [ST_W-1:0] {
        ST_NONE = 3'd0,
        ST_SW   = 3'd1,
        ST_SH   = 3'd2,
        ST_SB   = 3'd3
    } store_type_e;

    // One-entry write buffer state.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } buf_state_e;

    localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;

    // Buffered data-memory write request.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } dm_req_t;

endpackage

// File: rtl/mem_store_unit_aligner.sv
// Combinational byte-enable / lane replication and misalignment detection.
module store_aligner
    import mem_store_unit_pkg::*;
(
    input  logic [ST_W-1:0] store_type_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] data_i,
    output logic            is_store_o,
    output logic            misalign_o,
    output logic [BE_W-1:0] be_o,
    output logic [XLEN-1:0] wdata_o
);

    // Decode the store width into lanes and alignment status.
    always_comb begin
        is_store_o = 1'b0;
        misalign_o = 1'b0;
        be_o       = BE_NONE;
        wdata_o    = '0;
        case (store_type_i)
            ST_SW: begin
                is_store_o = 1'b1;
                misalign_o = (addr_lo_i != 2'b00);
                be_o       = BE_WORD;
                wdata_o    = data_i;
            end
            ST_SH: begin
                is_store_o = 1'b1;
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_o    = {2{data_i[15:0]}};
            end
            ST_SB: begin
                is_store_o = 1'b1;
                be_o       = BE_W'(BE_BYTE0 << addr_lo_i);
                wdata_o    = {4{data_i[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_store_unit.sv
// Memory-stage store unit: one-entry write buffer, misalignment exception, completion counter.
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [ST_W-1:0]  in_store_type,
    input  logic [XLEN-1:0]  in_addr,
    input  logic [XLEN-1:0]  in_data,
    input  logic [XLEN-1:0]  in_pc,
    output logic             dm_req_valid,
    input  logic             dm_req_ready,
    output logic [XLEN-1:0]  dm_addr,
    output logic [XLEN-1:0]  dm_wdata,
    output logic [BE_W-1:0]  dm_be,
    output logic             stall,
    output logic             misalign_exc,
    output logic [XLEN-1:0]  exc_pc,
    output logic [CNT_W-1:0] store_cnt
);

    buf_state_e       state_q, state_d;
    dm_req_t          req_q, req_d;
    logic             exc_q, exc_d;
    logic [XLEN-1:0]  exc_pc_q, exc_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             al_is_store;
    logic             al_misalign;
    logic [BE_W-1:0]  al_be;
    logic [XLEN-1:0]  al_wdata;

    logic             accept;
    logic             complete;

    store_aligner u_aligner (
        .store_type_i (in_store_type),
        .addr_lo_i    (in_addr[1:0]),
        .data_i       (in_data),
        .is_store_o   (al_is_store),
        .misalign_o   (al_misalign),
        .be_o         (al_be),
        .wdata_o      (al_wdata)
    );

    // Handshake: the buffer is busy only while it holds an unaccepted write.
    assign stall    = (state_q == S_FULL) && !dm_req_ready;
    assign complete = (state_q == S_FULL) && dm_req_ready;
    assign accept   = in_valid && al_is_store && !stall;

    // Next-state: reload on aligned acceptance, drain on completion, flag misaligned stores.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        exc_d    = 1'b0;
        exc_pc_d = exc_pc_q;
        cnt_d    = cnt_q;
        if (complete) begin
            state_d = S_EMPTY;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (accept) begin
            if (al_misalign) begin
                exc_d    = 1'b1;
                exc_pc_d = in_pc;
            end else begin
                state_d = S_FULL;
                req_d   = '{addr: {in_addr[XLEN-1:2], 2'b00}, wdata: al_wdata, be: al_be};
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_EMPTY;
            req_q    <= '0;
            exc_q    <= 1'b0;
            exc_pc_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            exc_q    <= exc_d;
            exc_pc_q <= exc_pc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dm_req_valid = (state_q == S_FULL);
    assign dm_addr      = req_q.addr;
    assign dm_wdata     = req_q.wdata;
    assign dm_be        = req_q.be;
    assign misalign_exc = exc_q;
    assign exc_pc       = exc_pc_q;
    assign store_cnt    = cnt_q;

endmodule

// File: doc/mem_store_unit.md
MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-store counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 in_valid  in  1  memory-stage instruction present this cycle.
REQ-005 in_store_type  in  3  0=none, 1=sw, 2=sh, 3=sb; 4-7 treated as none.
REQ-006 in_addr  in  32  byte address from the ALU result.
REQ-007 in_data  in  32  register value to store, right-aligned.
REQ-008 in_pc  in  32  PC of the memory-stage instruction.
REQ-009 dm_req_valid  out  1  data-memory write request pending.
REQ-010 dm_req_ready  in  1  data memory accepts the write this cycle.
REQ-011 dm_addr  out  32  word-aligned write address.
REQ-012 dm_wdata  out  32  lane-replicated write data.
REQ-013 dm_be  out  4  byte enables; bit i selects byte lane i (bits 8i+7:8i).
REQ-014 stall  out  1  freezes the pipeline stages upstream of the memory stage.
REQ-015 misalign_exc  out  1  one-cycle pulse for a misaligned store.
REQ-016 exc_pc  out  32  PC of the faulting store, valid while misalign_exc=1.
REQ-017 store_cnt  out  CNT_W  count of completed writes.

Function
REQ-018 A store is offered when in_valid=1 and in_store_type is 1-3; it is accepted on a rising edge where it is offered and stall=0.
REQ-019 The block holds a one-entry buffer with two states: EMPTY and FULL; dm_req_valid=1 exactly when the state is FULL.
REQ-020 An aligned store accepted in EMPTY moves the block to FULL; dm_req_valid rises one cycle after acceptance, so request latency is 1 cycle.
REQ-021 The write completes on an edge where dm_req_valid=1 and dm_req_ready=1; with no new acceptance, FULL moves to EMPTY and store_cnt increments by 1, wrapping at 2^CNT_W.
REQ-022 stall = FULL and not dm_req_ready; when a completion and an acceptance occur on the same edge, the buffer reloads with the new store, stays FULL, and store_cnt still increments.
REQ-023 While FULL and not ready, the buffered dm_addr, dm_wdata and dm_be SHALL hold stable.
REQ-024 dm_addr = {in_addr[31:2], 2'b00}, captured at acceptance.
REQ-025 For sw: dm_be=4'b1111 and dm_wdata=in_data.
REQ-026 For sh: dm_be=4'b0011 when addr[1]=0 and 4'b1100 when addr[1]=1; dm_wdata={2{in_data[15:0]}}.
REQ-027 For sb: dm_be=4'b0001 shifted left by addr[1:0]; dm_wdata={4{in_data[7:0]}}.
REQ-028 A store is misaligned when it is sw with addr[1:0]!=0 or sh with addr[0]=1; a misaligned store issues no request and does not change the buffer state.
REQ-029 When a misaligned store is accepted, misalign_exc=1 and exc_pc=in_pc on the next cycle only; otherwise misalign_exc=0.
REQ-030 A misaligned store offered while stall=1 is not accepted and raises no exception until it is accepted.
REQ-031 Non-store or invalid inputs SHALL neither change the state nor raise stall.

Reset
REQ-032 While reset=0: state EMPTY, dm_req_valid=0, dm_addr=0, dm_wdata=0, dm_be=0, stall=0, misalign_exc=0, exc_pc=0, store_cnt=0.
REQ-033 Reset asserted while FULL drops the pending write with no completion and no count increment.
REQ-034 The first acceptance is possible on the first rising edge after reset is released.

Structure
REQ-035 A shared package SHALL hold the store-type encodings, the EMPTY/FULL state encoding, and the byte-enable constants.
REQ-036 Byte-enable and data-lane generation SHALL be one combinational sub-module, store_aligner; mem_store_unit holds the buffer state machine, exception register and counter.

Verification
REQ-037 sw addr=0x1000 data=0xDEADBEEF, ready=1 -> next cycle valid=1, dm_addr=0x1000, be=1111, wdata=0xDEADBEEF; store_cnt=1 after the completing edge.
REQ-038 sb addr=0x2003 data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; sh addr=0x2002 data=0x1234 -> be=1100, wdata=0x12341234.
REQ-039 Hold ready=0 for 3 cycles with FULL and a second store offered -> stall=1 for 3 cycles with the outputs stable; when ready rises, the second store is accepted on the same edge, stays FULL, and store_cnt increments once.
REQ-040 sw addr=0x1002 pc=0x3040 -> no dm_req_valid, one-cycle misalign_exc=1 with exc_pc=0x3040; sh addr=0x1001 -> the same behaviour.
REQ-041 Drive reset low while FULL with ready=0 -> dm_req_valid=0 immediately (asynchronous), store_cnt unchanged, and the next store is accepted normally after release.
REQ-042 Preload store_cnt to 0xFFFF with CNT_W=16, then complete one store -> store_cnt=0x0000.
